// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB select/history block: source index map
// and helpers that size the select field from the history geometry.
package mem_wb_pkg;

  // Fixed source indices; history entries follow from SRC_HIST_BASE upward,
  // entry h lane k at SRC_HIST_BASE + h*LANES + k.
  localparam int SRC_ZERO      = 0;
  localparam int SRC_SFR       = 1;
  localparam int SRC_EXMEM     = 2;
  localparam int SRC_LD        = 3;
  localparam int SRC_HIST_BASE = 4;

  // Total number of selectable sources for a given history geometry.
  function automatic int num_sources(input int depth, input int lanes);
    return SRC_HIST_BASE + depth * lanes;
  endfunction

  // Width of one lane's encoded select field.
  function automatic int sel_width(input int depth, input int lanes);
    return $clog2(num_sources(depth, lanes));
  endfunction

endpackage

// File: rtl/mem_wb_lane_mux.sv
// One lane of the writeback source select. Purely combinational: picks one
// DATA_W slice out of the flat source vector and flags indices that do not
// name a source (those read as zero).
module mem_wb_lane_mux #(
  parameter int DATA_W  = 8,
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = 3
) (
  input  logic [NUM_SRC*DATA_W-1:0] src_vec,
  input  logic [SEL_W-1:0]          sel,
  output logic [DATA_W-1:0]         data,
  output logic                      range_err
);

  // Decode the select; out-of-range indices leave data at zero.
  always_comb begin
    data      = '0;
    range_err = (int'(sel) >= NUM_SRC);
    for (int s = 0; s < NUM_SRC; s++) begin
      if (int'(sel) == s) begin
        data = src_vec[s*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/mem_wb_data_select_hist.sv
// MEM/WB data path: per-lane source select feeding the MEM/WB register,
// which is the head of an N-deep writeback history shift register. Loads
// that are selected before their data is ready stall the pipe via ld_wait.
module mem_wb_data_select_hist
  import mem_wb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LANES      = 2,
  parameter int HIST_DEPTH = 2,
  localparam int NUM_SRC    = num_sources(HIST_DEPTH, LANES),
  localparam int SEL_W      = sel_width(HIST_DEPTH, LANES),
  localparam int ENTRY_W    = LANES * DATA_W
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [LANES*SEL_W-1:0]        sel,
  input  logic [DATA_W-1:0]             sfr_data,
  input  logic [ENTRY_W-1:0]            ex_mem_data,
  input  logic [ENTRY_W-1:0]            ld_res,
  input  logic                          ld_valid,
  output logic                          ld_wait,
  output logic [ENTRY_W-1:0]            mem_wb_data,
  output logic                          mem_wb_valid,
  output logic [HIST_DEPTH*ENTRY_W-1:0] hist_data,
  output logic                          sel_err
);

  logic [HIST_DEPTH-1:0][ENTRY_W-1:0] hist_reg;
  logic [HIST_DEPTH-1:0][ENTRY_W-1:0] hist_next;
  logic                               mem_wb_valid_reg;
  logic                               mem_wb_valid_next;
  logic                               sel_err_reg;
  logic                               sel_err_next;
  logic [HIST_DEPTH*ENTRY_W-1:0]      hist_flat;
  logic [ENTRY_W-1:0]                 mux_data;
  logic [LANES-1:0]                   lane_err;
  logic [LANES-1:0]                   lane_ld_sel;
  logic                               adv;

  assign hist_flat = hist_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [SEL_W-1:0]          lane_sel;
      logic [NUM_SRC*DATA_W-1:0] src_vec;

      assign lane_sel = sel[gi*SEL_W +: SEL_W];

      // Concatenation order must match the SRC_* index map: zero lowest,
      // then SFR, this lane's EX/MEM and load data, then the whole history
      // (pre-update values, so history reads forward the old contents).
      assign src_vec = {hist_flat,
                        ld_res[gi*DATA_W +: DATA_W],
                        ex_mem_data[gi*DATA_W +: DATA_W],
                        sfr_data,
                        {DATA_W{1'b0}}};

      assign lane_ld_sel[gi] = (int'(lane_sel) == SRC_LD);

      mem_wb_lane_mux #(
        .DATA_W  (DATA_W),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
      ) u_lane_mux (
        .src_vec   (src_vec),
        .sel       (lane_sel),
        .data      (mux_data[gi*DATA_W +: DATA_W]),
        .range_err (lane_err[gi])
      );
    end
  endgenerate

  // A lane reading the load result must wait until that result is valid.
  assign ld_wait = in_valid & ~ld_valid & (|lane_ld_sel);
  assign adv     = ~stall & ~ld_wait;

  // Next-state: flush inserts a bubble regardless of stall; otherwise an
  // advancing cycle captures the muxed lanes; otherwise everything holds.
  always_comb begin
    hist_next         = hist_reg;
    mem_wb_valid_next = mem_wb_valid_reg;
    if (flush || adv) begin
      for (int h = 1; h < HIST_DEPTH; h++) begin
        hist_next[h] = hist_reg[h-1];
      end
      hist_next[0]      = flush ? '0 : mux_data;
      mem_wb_valid_next = flush ? 1'b0 : in_valid;
    end
  end

  // Sticky flag: only selects actually consumed by a real instruction count.
  assign sel_err_next = sel_err_reg | (in_valid & adv & (|lane_err));

  // History, valid bit and error flag registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_reg         <= '0;
      mem_wb_valid_reg <= 1'b0;
      sel_err_reg      <= 1'b0;
    end else begin
      hist_reg         <= hist_next;
      mem_wb_valid_reg <= mem_wb_valid_next;
      sel_err_reg      <= sel_err_next;
    end
  end

  assign mem_wb_data  = hist_reg[0];
  assign mem_wb_valid = mem_wb_valid_reg;
  assign hist_data    = hist_flat;
  assign sel_err      = sel_err_reg;

endmodule
